ppu_op_sched: RTL and testbench

- Sequencing controller in front of the PPU arithmetic datapath (sign/total-exponent/mantissa core operation plus sign decision, result as sign, te, frac_full).
- Accepts one operation request at a time over a valid/ready handshake.
- Holds operands and opcode stable on the datapath for an opcode-dependent number of cycles, captures the result into an output register, and presents it over a second valid/ready handshake with backpressure.

---
 rtl/ppu_pkg.sv | 46 ++++
 rtl/ppu_lat_counter.sv | 37 +++
 rtl/ppu_op_sched.sv | 172 +++++++++++++++++
 tb/tb_ppu_op_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU operation scheduler and datapath.
// Holds the opcode encoding, the scheduler state encoding and the width
// helpers that derive every operand/result field width from the posit
// word width N.
//
// Unpacked operand layout (PIF): {sign, te, mant}
//   te_size(N)        : total-exponent field (regime * 2^ES + exponent, signed)
//   mant_size(N)      : mantissa incl. hidden bit
//   pif_size(N)       : 1 + te_size + mant_size
//   frac_full_size(N) : wide fraction result returned by the datapath
package ppu_pkg;

    localparam int ES      = 2;
    localparam int OP_SIZE = 2;

    typedef enum logic [OP_SIZE-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } ppu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    function automatic int te_size(input int n);
        return $clog2(n) + ES + 1;
    endfunction

    function automatic int mant_size(input int n);
        return n - ES - 2;
    endfunction

    function automatic int pif_size(input int n);
        return 1 + te_size(n) + mant_size(n);
    endfunction

    // Room for a full mantissa product plus two guard bits.
    function automatic int frac_full_size(input int n);
        return 2 * mant_size(n) + 2;
    endfunction

endpackage

// File: rtl/ppu_lat_counter.sv
// Loadable down-counter used to time how long operands must sit on the
// datapath before its result may be sampled.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; saturates at zero
//   zero      : high when the count is zero
module ppu_lat_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt;

    assign zero = (cnt == '0);

    // Count register: a load restarts the timing window; otherwise it
    // walks down towards zero and parks there until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ppu_op_sched.sv
// Sequencing controller in front of the PPU arithmetic datapath.
// Accepts one request at a time, holds opcode/operands on the datapath for
// an opcode-dependent number of cycles, captures the result and presents it
// downstream with backpressure. Retire and the next accept may share an edge.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : request handshake
//   op_in, pif1_in, pif2_in      : request opcode and unpacked operands
//   dp_op, dp_pif1, dp_pif2      : registered operands driven to datapath
//   dp_sign, dp_te, dp_frac_full : datapath result
//   out_valid/out_ready          : result handshake
//   sign_out, te_out, frac_full_out : registered result
//   busy                         : high while an operation is in EXEC or DONE
module ppu_op_sched
    import ppu_pkg::*;
#(
    parameter int N       = 16,
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OP_SIZE-1:0]            op_in,
    input  logic [pif_size(N)-1:0]        pif1_in,
    input  logic [pif_size(N)-1:0]        pif2_in,
    output logic [OP_SIZE-1:0]            dp_op,
    output logic [pif_size(N)-1:0]        dp_pif1,
    output logic [pif_size(N)-1:0]        dp_pif2,
    input  logic                          dp_sign,
    input  logic [te_size(N)-1:0]         dp_te,
    input  logic [frac_full_size(N)-1:0]  dp_frac_full,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sign_out,
    output logic [te_size(N)-1:0]         te_out,
    output logic [frac_full_size(N)-1:0]  frac_full_out,
    output logic                          busy
);

    localparam int PIF_W   = pif_size(N);
    localparam int TE_W    = te_size(N);
    localparam int FF_W    = frac_full_size(N);
    localparam int MAX_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int MAX_LAT = (MAX_AM > LAT_DIV) ? MAX_AM : LAT_DIV;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    sched_state_e        state, state_next;
    logic                accept, capture, cnt_dec, cnt_zero;
    logic [CW-1:0]       lat_load;
    logic [OP_SIZE-1:0]  op_q;
    logic [PIF_W-1:0]    pif1_q, pif2_q;
    logic                sign_q;
    logic [TE_W-1:0]     te_q;
    logic [FF_W-1:0]     frac_q;

    // Counter preload is L-1 so that the capture happens on the L-th EXEC cycle.
    always_comb begin
        lat_load = CW'(LAT_DIV - 1);
        case (ppu_op_e'(op_in))
            OP_ADD, OP_SUB: lat_load = CW'(LAT_ADD - 1);
            OP_MUL:         lat_load = CW'(LAT_MUL - 1);
            default:        lat_load = CW'(LAT_DIV - 1);
        endcase
    end

    ppu_lat_counter #(.CW(CW)) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (lat_load),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. In DONE the request side is only
    // opened when the consumer is taking the current result, which gives the
    // back-to-back retire+accept on a single edge.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        capture    = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_zero) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        accept = in_valid && in_ready;
    end

    // Operand registers feed the datapath directly, so the datapath inputs
    // cannot move between accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            pif1_q <= '0;
            pif2_q <= '0;
        end else if (accept) begin
            op_q   <= op_in;
            pif1_q <= pif1_in;
            pif2_q <= pif2_in;
        end
    end

    // Result registers sample the datapath once it has settled and then
    // hold, including after retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            te_q   <= '0;
            frac_q <= '0;
        end else if (capture) begin
            sign_q <= dp_sign;
            te_q   <= dp_te;
            frac_q <= dp_frac_full;
        end
    end

    assign dp_op         = op_q;
    assign dp_pif1       = pif1_q;
    assign dp_pif2       = pif2_q;
    assign sign_out      = sign_q;
    assign te_out        = te_q;
    assign frac_full_out = frac_q;
    assign out_valid     = (state == DONE);
    assign busy          = (state != IDLE);

`ifndef SYNTHESIS
    a_ready_valid_done: assert property (@(posedge clk) disable iff (rst)
        (in_ready && out_valid) |-> (state == DONE));

    a_dp_stable_exec: assert property (@(posedge clk) disable iff (rst)
        (state == EXEC) |=> ($stable(op_q) && $stable(pif1_q) && $stable(pif2_q)));

    a_out_stable_stall: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(sign_q) && $stable(te_q) && $stable(frac_q)));
`endif

endmodule

// File: tb/tb_ppu_op_sched.sv
// Self-checking bench for ppu_op_sched. A default-latency instance runs a
// table of hand-computed vectors plus back-to-back and reset corner cases;
// a second instance with LAT_ADD=3, LAT_MUL=1 runs a random latency
// scoreboard. Both instances see a small behavioural datapath whose results
// depend on opcode and both operands.
module tb_ppu_op_sched;
    import ppu_pkg::*;

    localparam int NW = 16;
    localparam int PW = pif_size(NW);
    localparam int TW = te_size(NW);
    localparam int MW = mant_size(NW);
    localparam int FW = frac_full_size(NW);
    localparam int RW = 1 + TW + FW;

    logic clk = 1'b0;
    logic rst;

    logic               in_valid, in_ready, out_valid, out_ready, busy;
    logic [OP_SIZE-1:0] op_in, dp_op;
    logic [PW-1:0]      pif1_in, pif2_in, dp_pif1, dp_pif2;
    logic               dp_sign, sign_out;
    logic [TW-1:0]      dp_te, te_out;
    logic [FW-1:0]      dp_frac_full, frac_full_out;

    logic               s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [OP_SIZE-1:0] s_op_in, s_dp_op;
    logic [PW-1:0]      s_pif1_in, s_pif2_in, s_dp_pif1, s_dp_pif2;
    logic               s_dp_sign, s_sign_out;
    logic [TW-1:0]      s_dp_te, s_te_out;
    logic [FW-1:0]      s_dp_frac_full, s_frac_full_out;

    int vec_count  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    // Behavioural datapath: sign/te depend on opcode, fraction packs opcode
    // and both mantissas so every operand bit is visible in the result.
    function automatic logic [RW-1:0] dp_model(input logic [1:0] op,
                                               input logic [PW-1:0] a,
                                               input logic [PW-1:0] b);
        logic          sa, sb, s;
        logic [TW-1:0] ta, tb, te;
        logic [MW-1:0] ma, mb;
        {sa, ta, ma} = a;
        {sb, tb, mb} = b;
        s  = sa;
        te = ta;
        case (op)
            2'd2:    begin s = sa ^ sb; te = ta + tb; end
            2'd3:    begin s = sa ^ sb; te = ta - tb; end
            default: begin s = sa;      te = ta;      end
        endcase
        return {s, te, op, ma, mb};
    endfunction

    assign {dp_sign, dp_te, dp_frac_full}       = dp_model(dp_op, dp_pif1, dp_pif2);
    assign {s_dp_sign, s_dp_te, s_dp_frac_full} = dp_model(s_dp_op, s_dp_pif1, s_dp_pif2);

    ppu_op_sched #(.N(NW), .LAT_ADD(1), .LAT_MUL(2), .LAT_DIV(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_in(op_in), .pif1_in(pif1_in), .pif2_in(pif2_in),
        .dp_op(dp_op), .dp_pif1(dp_pif1), .dp_pif2(dp_pif2),
        .dp_sign(dp_sign), .dp_te(dp_te), .dp_frac_full(dp_frac_full),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .te_out(te_out), .frac_full_out(frac_full_out),
        .busy(busy)
    );

    ppu_op_sched #(.N(NW), .LAT_ADD(3), .LAT_MUL(1), .LAT_DIV(4)) u_sweep (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op_in(s_op_in), .pif1_in(s_pif1_in), .pif2_in(s_pif2_in),
        .dp_op(s_dp_op), .dp_pif1(s_dp_pif1), .dp_pif2(s_dp_pif2),
        .dp_sign(s_dp_sign), .dp_te(s_dp_te), .dp_frac_full(s_dp_frac_full),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sign_out(s_sign_out), .te_out(s_te_out), .frac_full_out(s_frac_full_out),
        .busy(s_busy)
    );

    typedef struct {
        logic [1:0]  op;
        logic        s1;
        logic [6:0]  te1;
        logic [11:0] m1;
        logic        s2;
        logic [6:0]  te2;
        logic [11:0] m2;
        int          stall;
        logic        exp_sign;
        logic [6:0]  exp_te;
        logic [25:0] exp_frac;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One table vector on the default instance: accept, watch EXEC, measure
    // latency, hold the result under backpressure, then retire.
    task automatic applyStimulus(input int idx);
        vec_t          v;
        int            k;
        logic [PW-1:0] a, b;
        logic [RW-1:0] exp_res;
        v       = vecs[idx];
        a       = {v.s1, v.te1, v.m1};
        b       = {v.s2, v.te2, v.m2};
        exp_res = {v.exp_sign, v.exp_te, v.exp_frac};
        in_valid  = 1'b1;
        op_in     = v.op;
        pif1_in   = a;
        pif2_in   = b;
        out_ready = 1'b0;
        checkOutput($sformatf("vec%0d_ready_idle", idx), {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        op_in    = ~v.op;
        pif1_in  = ~a;
        pif2_in  = ~b;
        k = 1;
        while (!out_valid && k < 20) begin
            checkOutput($sformatf("vec%0d_exec_dp", idx),
                        {busy, in_ready, dp_op, dp_pif1, dp_pif2},
                        {1'b1, 1'b0, v.op, a, b});
            tick();
            k++;
        end
        checkOutput($sformatf("vec%0d_latency", idx), k, v.exp_lat);
        checkOutput($sformatf("vec%0d_result", idx),
                    {sign_out, te_out, frac_full_out}, exp_res);
        for (int s = 0; s < v.stall; s++) begin
            tick();
            checkOutput($sformatf("vec%0d_stall%0d", idx, s),
                        {out_valid, in_ready, sign_out, te_out, frac_full_out},
                        {1'b1, 1'b0, exp_res});
        end
        out_ready = 1'b1;
        #1;
        checkOutput($sformatf("vec%0d_ready_path", idx), {63'd0, in_ready}, 64'd1);
        tick();
        out_ready = 1'b0;
        checkOutput($sformatf("vec%0d_retired", idx), {out_valid, busy, in_ready}, 3'b001);
    endtask

    function automatic int sweep_lat(input logic [1:0] op);
        case (op)
            2'd0, 2'd1: return 4;
            2'd2:       return 2;
            default:    return 5;
        endcase
    endfunction

    initial begin
        logic [RW-1:0] exp_res;
        logic [PW-1:0] a, b;
        logic [1:0]    op;
        int            k, j;
        logic          r;

        vecs[0] = '{2'd0, 1'b1, 7'h05, 12'h123, 1'b0, 7'h02, 12'h456, 0, 1'b1, 7'h05, 26'h0123456, 2};
        vecs[1] = '{2'd1, 1'b0, 7'h10, 12'hABC, 1'b1, 7'h01, 12'h001, 1, 1'b0, 7'h10, 26'h1ABC001, 2};
        vecs[2] = '{2'd2, 1'b1, 7'h03, 12'h800, 1'b1, 7'h04, 12'hC00, 2, 1'b0, 7'h07, 26'h2800C00, 3};
        vecs[3] = '{2'd3, 1'b0, 7'h02, 12'hFFF, 1'b1, 7'h05, 12'h010, 3, 1'b1, 7'h7D, 26'h3FFF010, 5};
        vecs[4] = '{2'd2, 1'b0, 7'h7F, 12'h000, 1'b0, 7'h01, 12'hFFF, 0, 1'b0, 7'h00, 26'h2000FFF, 3};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op_in = '0; pif1_in = '0; pif2_in = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_op_in = '0; s_pif1_in = '0; s_pif2_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        $display("[TB] reset released");
        checkOutput("reset_ctrl", {out_valid, busy, in_ready}, 3'b001);
        checkOutput("reset_dp", {dp_op, dp_pif1, dp_pif2}, '0);
        checkOutput("reset_out", {sign_out, te_out, frac_full_out}, '0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(i);
        end

        $display("[TB] back-to-back MUL then ADD");
        in_valid  = 1'b1;
        op_in     = 2'd2;
        pif1_in   = {vecs[2].s1, vecs[2].te1, vecs[2].m1};
        pif2_in   = {vecs[2].s2, vecs[2].te2, vecs[2].m2};
        out_ready = 1'b1;
        tick();
        op_in   = 2'd0;
        pif1_in = {vecs[0].s1, vecs[0].te1, vecs[0].m1};
        pif2_in = {vecs[0].s2, vecs[0].te2, vecs[0].m2};
        checkOutput("b2b_exec1", {in_ready, out_valid, dp_op}, {1'b0, 1'b0, 2'd2});
        tick();
        checkOutput("b2b_exec2", {out_valid, in_ready}, 2'b00);
        tick();
        checkOutput("b2b_mul_done", {out_valid, in_ready, sign_out, te_out, frac_full_out},
                    {1'b1, 1'b1, vecs[2].exp_sign, vecs[2].exp_te, vecs[2].exp_frac});
        tick();
        in_valid = 1'b0;
        checkOutput("b2b_add_accepted", {out_valid, busy, dp_op, dp_pif1},
                    {1'b0, 1'b1, 2'd0, vecs[0].s1, vecs[0].te1, vecs[0].m1});
        tick();
        checkOutput("b2b_add_done", {out_valid, sign_out, te_out, frac_full_out},
                    {1'b1, vecs[0].exp_sign, vecs[0].exp_te, vecs[0].exp_frac});
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_idle", {out_valid, busy, in_ready}, 3'b001);

        $display("[TB] reset during DIV execution");
        in_valid = 1'b1;
        op_in    = 2'd3;
        pif1_in  = {vecs[3].s1, vecs[3].te1, vecs[3].m1};
        pif2_in  = {vecs[3].s2, vecs[3].te2, vecs[3].m2};
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_ctrl", {out_valid, busy, in_ready}, 3'b001);
        checkOutput("midrst_dp_out", {dp_op, dp_pif1, dp_pif2, sign_out, te_out, frac_full_out}, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("midrst_quiet%0d", i), {out_valid, busy}, 2'b00);
        end
        applyStimulus(0);

        $display("[TB] latency sweep LAT_ADD=3 LAT_MUL=1 LAT_DIV=4");
        for (int n = 0; n < 1000; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = PW'($urandom);
            b  = PW'($urandom);
            exp_res = dp_model(op, a, b);
            s_in_valid  = 1'b1;
            s_op_in     = op;
            s_pif1_in   = a;
            s_pif2_in   = b;
            s_out_ready = 1'b0;
            checkOutput($sformatf("sweep%0d_ready", n), {63'd0, s_in_ready}, 64'd1);
            tick();
            s_in_valid = 1'b0;
            k = 1;
            while (!s_out_valid && k < 20) begin
                tick();
                k++;
            end
            checkOutput($sformatf("sweep%0d_op%0d_latency", n, op), k, sweep_lat(op));
            checkOutput($sformatf("sweep%0d_result", n),
                        {s_sign_out, s_te_out, s_frac_full_out}, exp_res);
            j = 0;
            r = 1'b0;
            while (!r) begin
                r = (j >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
                s_out_ready = r;
                tick();
                j++;
                if (!r) begin
                    checkOutput($sformatf("sweep%0d_hold", n),
                                {s_out_valid, s_sign_out, s_te_out, s_frac_full_out},
                                {1'b1, exp_res});
                end
            end
            s_out_ready = 1'b0;
            checkOutput($sformatf("sweep%0d_retired", n), {s_out_valid, s_busy}, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
